pwm_compare: RTL and testbench
==============================

# pwm_compare

Downstream consumer of the free-running binary counter: samples the counter value every cycle and produces a registered PWM output. The output is high while the count is below a programmable duty threshold. Duty updates pass through a one-deep valid/ready pending slot and take effect only at a counter wrap (MAX→0), so every PWM period is glitch-free. A small enable state machine starts and stops PWM on period boundaries.

## Interface
- N, 4, counter width; must match the upstream counter's N.
- clk  in  1  single clock; all state on posedge clk.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- cnt  in  N  counter value from the upstream binary counter.
- en  in  1  request PWM generation; start and stop are aligned to wraps.
- cfg_valid  in  1  new duty offered.
- cfg_duty  in  N+1  duty in counts, 0..2^N; values above 2^N are clipped to 2^N on acceptance.
- cfg_ready  out  1  pending slot empty; combinational, equals !pend_valid.
- pwm  out  1  registered PWM output.
- wrap_tick  out  1  registered one-cycle pulse, one cycle after a wrap is sampled.
- busy  out  1  state != IDLE; registered.

## Operation
- **Wrap detection**
  - prev_cnt register is reset to 0.
  - wrap = (prev_cnt == {N{1'b1}}) && (cnt == 0).
  - Any other jump is not a wrap, including a counter reload or any value-to-0 jump from a value other than MAX.
  - wrap_tick pulses in every state, including IDLE.
- **Configuration**
  - A transfer occurs when cfg_valid && cfg_ready; the clipped cfg_duty is stored in pend, and pend_valid is set.
  - cfg_valid may be held; the source must keep cfg_duty stable until the transfer.
- **Apply at wrap**
  - duty_eff = (wrap && pend_valid) ? pend : duty_active.
  - On a wrap with pend_valid set: duty_active <= pend and pend_valid <= 0.
  - A transfer in the same cycle as a wrap sees pend_valid=0, so it loads pend and is applied at the following wrap, not the current one.
- **Compare**
  - cmp = ({1'b0,cnt} < duty_eff), an unsigned (N+1)-bit compare.
  - duty 0 gives pwm constantly low; duty 2^N gives pwm constantly high while active.
- **State machine** (IDLE, SYNC, RUN, DRAIN); transitions are evaluated each cycle:
  - IDLE: en → SYNC.
  - SYNC: !en → IDLE; wrap → RUN.
  - RUN: !en → DRAIN.
  - DRAIN: en → RUN; else wrap → IDLE.
- **Output gating**
  - active = (state==RUN) || (state==SYNC && wrap) || (state==DRAIN && !wrap).
  - pwm <= active && cmp.
  - As a result, the first RUN period starts on the wrap sample itself, and DRAIN finishes the current period with pwm low from the wrap sample onward.
- **Reset values**
  - state=IDLE, pwm=0, wrap_tick=0, busy=0.
  - duty_active=0, pend_valid=0 (so cfg_ready=1), prev_cnt=0.
  - Reset mid-operation discards any pending duty and in-progress period; there is no partial-period output after reset.

## Timing
- pwm latency: 1 cycle. pwm at edge t+1 reflects cnt and duty_eff sampled at edge t.
- wrap_tick: high for exactly one cycle, at the edge after the cycle in which cnt==0 follows MAX.
- busy: rises 1 cycle after en is sampled in IDLE; falls 1 cycle after the DRAIN→IDLE wrap.
- cfg_ready:
  - Falls the cycle after an accepted transfer.
  - Rises the cycle after the wrap that consumes pend.
- Maximum config throughput: one duty per counter period.

## Structure
- Shared package pwm_pkg:
  - state enum (IDLE, SYNC, RUN, DRAIN), 2 bits;
  - helper constant for count MAX as a function of N.
- Sub-module wrap_detect (N parameter): holds prev_cnt and outputs the combinational wrap.
- Top level holds the config slot, compare, FSM and output registers.

## Test plan
All scenarios use N=4, with the counter running 0..15 and advancing once per clock.
- Reset held 3 cycles mid-RUN with duty=8 and pending=3 → pwm=0, busy=0, wrap_tick=0, cfg_ready=1; after release with en=1, the state waits in SYNC for a wrap.
- en=1, duty=4 accepted during SYNC → pwm stays low until the first wrap, then runs 4 cycles high / 12 low per 16, first high one cycle after the cnt=0 sample; wrap_tick is one cycle wide every 16 cycles.
- duty=0 → pwm never high; duty=16 → pwm high every cycle in RUN; cfg_duty=20 → clipped to 16, same waveform as duty=16.
- Back-to-back configs: duty=4 then duty=12 with cfg_valid held:
  - cfg_ready is low until the next wrap;
  - period k+1 uses 4, period k+2 uses 12;
  - a transfer that coincides with a wrap applies one period later.
- en dropped at cnt=6 in RUN with duty=10 → DRAIN; pwm completes the high phase through cnt=9; pwm is low from the wrap; busy falls 1 cycle after the wrap. A variant re-raises en at cnt=12 → returns to RUN with no gap.
- Counter reloaded from 15 to 7, and separately from 9 to 0 → no wrap_tick, pending duty not applied, SYNC does not advance.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM compare block that follows the
// free-running binary counter.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } pwm_state_t;

  // Terminal count of an n-bit up-counter; the value that precedes a wrap.
  function automatic int cnt_max(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/pwm_compare_wrap_detect.sv
// Detects the MAX->0 transition of the upstream counter; any other jump to 0
// (reload, reset of the counter) is deliberately not treated as a wrap.
module wrap_detect
  import pwm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] cnt,
  output logic         wrap
);

  localparam logic [N-1:0] CNT_MAX = N'(cnt_max(N));

  logic [N-1:0] prev_cnt_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cnt_p1 <= '0;
    end else begin
      prev_cnt_p1 <= cnt;
    end
  end

  assign wrap = (prev_cnt_p1 == CNT_MAX) && (cnt == '0);

endmodule

// File: rtl/pwm_compare.sv
// Registered PWM generator driven by an external counter. Duty changes and
// start/stop are both aligned to counter wraps so no period is ever truncated.
module pwm_compare
  import pwm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [N-1:0] cnt,
  input  logic       en,
  input  logic       cfg_valid,
  input  logic [N:0] cfg_duty,
  output logic       cfg_ready,
  output logic       pwm,
  output logic       wrap_tick,
  output logic       busy
);

  localparam logic [N:0] DUTY_FULL = {1'b1, {N{1'b0}}};

  function automatic logic [N:0] clip_duty(input logic [N:0] d);
    return (d > DUTY_FULL) ? DUTY_FULL : d;
  endfunction

  pwm_state_t state;
  logic       wrap;
  logic [N:0] pend;
  logic       pend_valid;
  logic [N:0] duty_active;
  logic [N:0] duty_eff;
  logic       cfg_xfer;
  logic       cmp;
  logic       active;

  wrap_detect #(.N(N)) u_wrap_detect (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  assign cfg_ready = !pend_valid;
  assign cfg_xfer  = cfg_valid && cfg_ready;

  // A pending duty is used from the wrap sample itself, so the new period
  // starts with the new threshold.
  assign duty_eff = (wrap && pend_valid) ? pend : duty_active;
  assign cmp      = ({1'b0, cnt} < duty_eff);
  assign active   = (state == RUN) || (state == SYNC && wrap) ||
                    (state == DRAIN && !wrap);

  // Pending slot payload; only meaningful while pend_valid is set.
  always_ff @(posedge clk) begin
    if (cfg_xfer) begin
      pend <= clip_duty(cfg_duty);
    end
  end

  // Stage p1: slot control, duty apply and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      duty_active <= '0;
      pwm         <= 1'b0;
      wrap_tick   <= 1'b0;
    end else begin
      if (wrap && pend_valid) begin
        duty_active <= pend;
        pend_valid  <= 1'b0;
      end
      if (cfg_xfer) begin
        pend_valid <= 1'b1;
      end
      pwm       <= active && cmp;
      wrap_tick <= wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state <= SYNC;
            busy  <= 1'b1;
          end
        end
        SYNC: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (en) begin
            state <= RUN;
          end else if (wrap) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare with N=4: table-driven start-up sequence
// followed by hand-written multi-period scenarios.
module tb_pwm_compare;

  logic       clk;
  logic       reset;
  logic [3:0] cnt;
  logic       en;
  logic       cfg_valid;
  logic [4:0] cfg_duty;
  logic       cfg_ready;
  logic       pwm;
  logic       wrap_tick;
  logic       busy;

  int errors;
  int checks;

  pwm_compare #(.N(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt       (cnt),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_duty  (cfg_duty),
    .cfg_ready (cfg_ready),
    .pwm       (pwm),
    .wrap_tick (wrap_tick),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       cfg_valid;
    logic [4:0] cfg_duty;
    logic [3:0] cnt;
    logic       pwm;
    logic       wrap_tick;
    logic       busy;
    logic       ready;
  } vec_t;

  vec_t vecs[40];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cnt=%0d, t=%0t)", name, act, exp, cnt, $time);
    end
  endtask

  task automatic tick(input int c);
    cnt = 4'(c);
    @(posedge clk);
    #1;
  endtask

  // One full counter period 0..15 at a known duty; optional offer at cnt=1.
  task automatic period_check(input string tag, input int duty, input int offer);
    for (int c = 0; c < 16; c++) begin
      cfg_valid = (offer >= 0) && (c == 1);
      cfg_duty  = (offer >= 0) ? 5'(offer) : 5'd0;
      tick(c);
      chk({tag, "_pwm"}, pwm, c < duty);
      chk({tag, "_wrap_tick"}, wrap_tick, c == 0);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_ready"}, cfg_ready, (offer >= 0) ? (c == 0) : 1'b1);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_duty  = '0;
    cnt       = '0;

    // Power-on reset
    repeat (3) tick(0);
    chk("rst_pwm", pwm, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wrap_tick", wrap_tick, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    reset = 1'b0;

    // Start-up: en at cnt=10, duty=4 accepted in SYNC, first wrap at k=6.
    for (int k = 0; k < 40; k++) begin
      vecs[k].en        = 1'b1;
      vecs[k].cfg_valid = (k == 1);
      vecs[k].cfg_duty  = 5'd4;
      vecs[k].cnt       = 4'((10 + k) % 16);
      vecs[k].pwm       = (k >= 6) && (((10 + k) % 16) < 4);
      vecs[k].wrap_tick = (k >= 6) && (((10 + k) % 16) == 0);
      vecs[k].busy      = 1'b1;
      vecs[k].ready     = !((k >= 1) && (k < 6));
    end
    for (int k = 0; k < 40; k++) begin
      en        = vecs[k].en;
      cfg_valid = vecs[k].cfg_valid;
      cfg_duty  = vecs[k].cfg_duty;
      tick(int'(vecs[k].cnt));
      chk("tbl_pwm", pwm, vecs[k].pwm);
      chk("tbl_wrap_tick", wrap_tick, vecs[k].wrap_tick);
      chk("tbl_busy", busy, vecs[k].busy);
      chk("tbl_ready", cfg_ready, vecs[k].ready);
    end
    cfg_valid = 1'b0;

    // Finish the duty=4 period while offering duty=0.
    for (int c = 2; c < 16; c++) begin
      cfg_valid = (c == 2);
      cfg_duty  = 5'd0;
      tick(c);
      chk("fin4_pwm", pwm, c < 4);
      chk("fin4_ready", cfg_ready, 1'b0);
    end
    cfg_valid = 1'b0;

    period_check("duty0", 0, 16);
    period_check("duty16", 16, 20);
    period_check("duty20clip", 16, -1);

    // Back-to-back: 4 accepted at cnt=1, then 12 held until the slot frees.
    for (int c = 0; c < 16; c++) begin
      cfg_valid = (c >= 1);
      cfg_duty  = (c <= 1) ? 5'd4 : 5'd12;
      tick(c);
      chk("b2b_k_pwm", pwm, 1'b1);
      chk("b2b_k_ready", cfg_ready, c == 0);
    end
    for (int c = 0; c < 16; c++) begin
      cfg_valid = (c <= 1);
      cfg_duty  = 5'd12;
      tick(c);
      chk("b2b_k1_pwm", pwm, c < 4);
      chk("b2b_k1_ready", cfg_ready, c == 0);
    end
    cfg_valid = 1'b0;
    period_check("b2b_k2", 12, -1);
    // Offer coincides with the wrap: loaded now, applied next period.
    for (int c = 0; c < 16; c++) begin
      cfg_valid = (c == 0);
      cfg_duty  = 5'd2;
      tick(c);
      chk("wrapcfg_pwm", pwm, c < 12);
      chk("wrapcfg_ready", cfg_ready, 1'b0);
    end
    cfg_valid = 1'b0;
    period_check("wrapcfg_next", 2, 10);

    // Drain: en dropped at cnt=6 with duty=10.
    for (int c = 0; c < 16; c++) begin
      en = (c < 6);
      tick(c);
      chk("drain_pwm", pwm, c < 10);
      chk("drain_busy", busy, 1'b1);
    end
    tick(0);
    chk("drain_end_pwm", pwm, 1'b0);
    chk("drain_end_busy", busy, 1'b0);
    chk("drain_end_wrap_tick", wrap_tick, 1'b1);
    for (int c = 1; c < 3; c++) begin
      tick(c);
      chk("idle_pwm", pwm, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end

    // Restart, then drop en at 6 and re-raise at 12: no gap in the next period.
    for (int c = 3; c < 16; c++) begin
      en = 1'b1;
      tick(c);
      chk("sync_pwm", pwm, 1'b0);
      chk("sync_busy", busy, 1'b1);
    end
    for (int c = 0; c < 16; c++) begin
      en = (c < 6) || (c >= 12);
      tick(c);
      chk("rerun_pwm", pwm, c < 10);
      chk("rerun_busy", busy, 1'b1);
    end
    for (int c = 0; c < 16; c++) begin
      en = 1'b1;
      tick(c);
      chk("nogap_pwm", pwm, c < 10);
    end

    // Counter reloads (9->0, 15->7) must not apply the pending duty=3.
    for (int c = 0; c < 10; c++) begin
      cfg_valid = (c == 1);
      cfg_duty  = 5'd3;
      tick(c);
      chk("rl_pre_pwm", pwm, c < 10);
    end
    cfg_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick(c);
      chk("rl90_pwm", pwm, c < 10);
      chk("rl90_wrap_tick", wrap_tick, 1'b0);
      chk("rl90_ready", cfg_ready, 1'b0);
    end
    for (int c = 7; c < 16; c++) begin
      tick(c);
      chk("rl157_pwm", pwm, c < 10);
      chk("rl157_wrap_tick", wrap_tick, 1'b0);
      chk("rl157_ready", cfg_ready, 1'b0);
    end
    period_check("rl_apply3", 3, 8);

    // Reset mid-RUN with duty=8 active and duty=3 pending.
    for (int c = 0; c < 5; c++) begin
      cfg_valid = (c == 1);
      cfg_duty  = 5'd3;
      tick(c);
      chk("prerst_pwm", pwm, c < 8);
    end
    cfg_valid = 1'b0;
    reset = 1'b1;
    for (int c = 5; c < 8; c++) begin
      tick(c);
      chk("midrst_pwm", pwm, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_wrap_tick", wrap_tick, 1'b0);
      chk("midrst_ready", cfg_ready, 1'b1);
    end
    reset     = 1'b0;
    en        = 1'b1;
    cfg_valid = 1'b1;
    cfg_duty  = 5'd16;
    tick(8);
    cfg_valid = 1'b0;
    chk("post_busy", busy, 1'b1);
    chk("post_ready", cfg_ready, 1'b0);
    tick(9);
    chk("post_pwm", pwm, 1'b0);
    // Fake wraps while in SYNC.
    for (int c = 0; c < 16; c++) begin
      tick(c);
      chk("sync90_pwm", pwm, 1'b0);
      chk("sync90_wrap_tick", wrap_tick, 1'b0);
      chk("sync90_ready", cfg_ready, 1'b0);
    end
    tick(7);
    chk("sync157_pwm", pwm, 1'b0);
    chk("sync157_wrap_tick", wrap_tick, 1'b0);
    en = 1'b0;
    tick(8);
    chk("sync_drop_busy", busy, 1'b0);
    en = 1'b1;
    tick(9);
    chk("sync_again_busy", busy, 1'b1);
    for (int c = 10; c < 16; c++) begin
      tick(c);
      chk("sync_wait_pwm", pwm, 1'b0);
    end
    for (int c = 0; c < 4; c++) begin
      tick(c);
      chk("sync_run_pwm", pwm, 1'b1);
      chk("sync_run_wrap_tick", wrap_tick, c == 0);
      chk("sync_run_ready", cfg_ready, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
